// File: rtl/bb_stream_buffer.sv
// rtl/bb_stream_buffer.sv - valid/ready show-ahead FIFO buffer between byte source and LCD controller
module bb_stream_buffer #(
    parameter int PAYLOAD_BITS = 8,
    parameter int DEPTH        = 4,
    parameter bit ZERO_IDLE    = 1'b1
) (
    input  logic                       CLK_I,
    input  logic                       RST_N_I,
    input  logic [PAYLOAD_BITS-1:0]    DATA_I,
    input  logic                       VALID_I,
    output logic                       READY_O,
    output logic [PAYLOAD_BITS-1:0]    DATA_O,
    output logic                       VALID_O,
    input  logic                       BB_READY_I,
    input  logic                       FLUSH_I,
    output logic [$clog2(DEPTH):0]     COUNT_O
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q,  count_d;
    logic [PAYLOAD_BITS-1:0] last_q,   last_d;

    logic push;
    logic pop;

    assign READY_O = (count_q != FULL_COUNT);
    assign VALID_O = (count_q != '0);
    assign COUNT_O = count_q;

    // Handshakes are judged on pre-edge state only, so a full buffer never passes through.
    assign push = VALID_I && READY_O;
    assign pop  = VALID_O && BB_READY_I;

    always_comb begin
        if (count_q != '0) begin
            DATA_O = mem_q[rd_ptr_q];
        end else if (ZERO_IDLE) begin
            DATA_O = '0;
        end else begin
            DATA_O = last_q;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (FLUSH_I) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            last_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                last_d   = mem_q[rd_ptr_q];
            end
            count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge CLK_I) begin
        if (push && !FLUSH_I) begin
            mem_q[wr_ptr_q] <= DATA_I;
        end
    end

endmodule

// File: tb/tb_bb_stream_buffer.sv
// tb/tb_bb_stream_buffer.sv - self-checking bench for bb_stream_buffer with queue reference model
module tb_bb_stream_buffer;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] di = 8'h00;
    logic       vi = 1'b0;
    logic       br = 1'b0;
    logic       fl = 1'b0;

    logic       rdy0, val0, rdy1, val1;
    logic [7:0] dat0, dat1;
    logic [2:0] cnt0, cnt1;

    int passed = 0;
    int total  = 0;

    logic [7:0] q[$];
    logic [7:0] lv = 8'h00;

    bb_stream_buffer #(.PAYLOAD_BITS(8), .DEPTH(D), .ZERO_IDLE(1'b1)) dut0 (
        .CLK_I(clk), .RST_N_I(rst_n), .DATA_I(di), .VALID_I(vi), .READY_O(rdy0),
        .DATA_O(dat0), .VALID_O(val0), .BB_READY_I(br), .FLUSH_I(fl), .COUNT_O(cnt0)
    );

    bb_stream_buffer #(.PAYLOAD_BITS(8), .DEPTH(D), .ZERO_IDLE(1'b0)) dut1 (
        .CLK_I(clk), .RST_N_I(rst_n), .DATA_I(di), .VALID_I(vi), .READY_O(rdy1),
        .DATA_O(dat1), .VALID_O(val1), .BB_READY_I(br), .FLUSH_I(fl), .COUNT_O(cnt1)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] expect_status(input bit zi);
        logic [7:0] d;
        if (q.size() != 0) d = q[0];
        else if (zi)       d = 8'h00;
        else               d = lv;
        return {q.size() != D, q.size() != 0, 3'(q.size()), d};
    endfunction

    // Apply one cycle of stimulus, advance the model at the edge, return 1ns after it.
    task automatic cycle(input logic v, input logic [7:0] d, input logic b, input logic f);
        bit take;
        vi = v; di = d; br = b; fl = f;
        @(posedge clk);
        take = v && (q.size() < D);
        if (f) begin
            q.delete();
            lv = 8'h00;
        end else begin
            if (b && q.size() > 0) lv = q.pop_front();
            if (take) q.push_back(d);
        end
        #1;
        vi = 1'b0; br = 1'b0; fl = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({rdy0, val0, cnt0, dat0} !== {1'b1, 1'b0, 3'd0, 8'h00})
            $display("FAIL reset_dut0 got %h want %h", {rdy0, val0, cnt0, dat0}, {1'b1, 1'b0, 3'd0, 8'h00});
        else passed++;
        total++; if ({rdy1, val1, cnt1, dat1} !== {1'b1, 1'b0, 3'd0, 8'h00})
            $display("FAIL reset_dut1 got %h want %h", {rdy1, val1, cnt1, dat1}, {1'b1, 1'b0, 3'd0, 8'h00});
        else passed++;
        @(negedge clk) rst_n = 1'b1;
        q.delete(); lv = 8'h00;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if ({rdy0, val0, cnt0} !== {1'b1, 1'b0, 3'd0})
            $display("FAIL reset_release got %b want %b", {rdy0, val0, cnt0}, {1'b1, 1'b0, 3'd0});
        else passed++;
    endtask

    task automatic test_basic();
        logic [7:0] words [3];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        for (int i = 0; i < 3; i++) cycle(1'b1, words[i], 1'b0, 1'b0);
        total++; if ({cnt0, val0, dat0, rdy0} !== {3'd3, 1'b1, 8'h11, 1'b1})
            $display("FAIL basic_filled got %h want %h", {cnt0, val0, dat0, rdy0}, {3'd3, 1'b1, 8'h11, 1'b1});
        else passed++;
        for (int i = 0; i < 3; i++) begin
            total++; if (dat0 !== words[i])
                $display("FAIL basic_drain%0d got %h want %h", i, dat0, words[i]);
            else passed++;
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        total++; if ({val0, dat0} !== {1'b0, 8'h00})
            $display("FAIL basic_idle_zero got %h want %h", {val0, dat0}, {1'b0, 8'h00});
        else passed++;
        total++; if ({val1, dat1} !== {1'b0, 8'h33})
            $display("FAIL basic_idle_hold got %h want %h", {val1, dat1}, {1'b0, 8'h33});
        else passed++;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        total++; if ({cnt0, rdy0} !== {3'd4, 1'b0})
            $display("FAIL full_count got %h want %h", {cnt0, rdy0}, {3'd4, 1'b0});
        else passed++;
        cycle(1'b1, 8'hA4, 1'b0, 1'b0);
        total++; if ({cnt0, dat0} !== {3'd4, 8'hA0})
            $display("FAIL full_no_overwrite got %h want %h", {cnt0, dat0}, {3'd4, 8'hA0});
        else passed++;
        cycle(1'b1, 8'hA4, 1'b1, 1'b0);
        total++; if ({cnt0, rdy0, dat0} !== {3'd3, 1'b1, 8'hA1})
            $display("FAIL full_no_passthru got %h want %h", {cnt0, rdy0, dat0}, {3'd3, 1'b1, 8'hA1});
        else passed++;
        cycle(1'b1, 8'hA4, 1'b0, 1'b0);
        total++; if (cnt0 !== 3'd4)
            $display("FAIL full_accept got %0d want 4", cnt0);
        else passed++;
        for (int i = 1; i < 5; i++) begin
            total++; if (dat0 !== 8'hA0 + 8'(i))
                $display("FAIL full_drain%0d got %h want %h", i, dat0, 8'hA0 + 8'(i));
            else passed++;
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        total++; if (val0 !== 1'b0)
            $display("FAIL full_empty got %b want 0", val0);
        else passed++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b1, 1'b0);
            total++; if ({cnt0, dat0} !== {3'd1, 8'(i)})
                $display("FAIL wrap%0d got %h want %h", i, {cnt0, dat0}, {3'd1, 8'(i)});
            else passed++;
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if ({val0, cnt0} !== {1'b0, 3'd0})
            $display("FAIL wrap_drained got %h want %h", {val0, cnt0}, {1'b0, 3'd0});
        else passed++;
    endtask

    task automatic test_idle_hold();
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if ({val1, dat1} !== {1'b0, 8'h5A})
            $display("FAIL hold_value got %h want %h", {val1, dat1}, {1'b0, 8'h5A});
        else passed++;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if ({dat1, cnt1} !== {8'h00, 3'd0})
            $display("FAIL hold_flush got %h want %h", {dat1, cnt1}, {8'h00, 3'd0});
        else passed++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b1);
        total++; if ({rdy0, val0, cnt0, dat0} !== {1'b1, 1'b0, 3'd0, 8'h00})
            $display("FAIL flush_clear got %h want %h", {rdy0, val0, cnt0, dat0}, {1'b1, 1'b0, 3'd0, 8'h00});
        else passed++;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if ({val0, cnt0} !== {1'b0, 3'd0})
            $display("FAIL flush_no_store got %h want %h", {val0, cnt0}, {1'b0, 3'd0});
        else passed++;
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 8'h91, 1'b0, 1'b0);
        cycle(1'b1, 8'h92, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        q.delete(); lv = 8'h00;
        #1;
        total++; if ({val0, cnt0, rdy0} !== {1'b0, 3'd0, 1'b1})
            $display("FAIL areset_immediate got %b want %b", {val0, cnt0, rdy0}, {1'b0, 3'd0, 1'b1});
        else passed++;
        total++; if ({val1, cnt1, dat1} !== {1'b0, 3'd0, 8'h00})
            $display("FAIL areset_hold_reg got %h want %h", {val1, cnt1, dat1}, {1'b0, 3'd0, 8'h00});
        else passed++;
        @(negedge clk) rst_n = 1'b1;
        cycle(1'b1, 8'h42, 1'b0, 1'b0);
        total++; if ({cnt0, dat0} !== {3'd1, 8'h42})
            $display("FAIL areset_after got %h want %h", {cnt0, dat0}, {3'd1, 8'h42});
        else passed++;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [13:0] e0, e1;
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 40) == 0));
            e0 = expect_status(1'b1);
            e1 = expect_status(1'b0);
            total++; if ({rdy0, val0, cnt0, dat0} !== e0)
                $display("FAIL random_dut0 cycle %0d got %h want %h", n, {rdy0, val0, cnt0, dat0}, e0);
            else passed++;
            total++; if ({rdy1, val1, cnt1, dat1} !== e1)
                $display("FAIL random_dut1 cycle %0d got %h want %h", n, {rdy1, val1, cnt1, dat1}, e1);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_idle_hold();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
